// File: rtl/regfile_pkg.sv
// Shared register-file constants and helpers for packing and unpacking
// the multi-port read buses.
package regfile_pkg;

   localparam int DEFAULT_DATA_W   = 16;
   localparam int DEFAULT_NUM_REGS = 4;
   localparam int MAX_FIELD_W      = 64;
   localparam int MAX_BUS_W        = 256;

   function automatic int addr_width(input int num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

   function automatic logic [MAX_FIELD_W-1:0] get_rd_addr(
      input logic [MAX_BUS_W-1:0] bus,
      input int                   port,
      input int                   width
   );
      logic [MAX_BUS_W-1:0] shifted;
      shifted = bus >> (port * width);
      return MAX_FIELD_W'(shifted) & ({MAX_FIELD_W{1'b1}} >> (MAX_FIELD_W - width));
   endfunction

   // Inserts one port's field into a packed bus, leaving the other ports intact.
   function automatic logic [MAX_BUS_W-1:0] put_rd_data(
      input logic [MAX_BUS_W-1:0]   bus,
      input int                     port,
      input int                     width,
      input logic [MAX_FIELD_W-1:0] data
   );
      logic [MAX_BUS_W-1:0] mask;
      mask = MAX_BUS_W'({MAX_FIELD_W{1'b1}} >> (MAX_FIELD_W - width)) << (port * width);
      return (bus & ~mask) | ((MAX_BUS_W'(data) << (port * width)) & mask);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy flag per register plus a running count
// of reserved registers.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NUM_REGS = DEFAULT_NUM_REGS,
   parameter  int ZERO_REG = 0,
   localparam int AW       = addr_width(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic                rsv_en,
   input  logic [AW-1:0]       rsv_addr,
   output logic [NUM_REGS-1:0] busy_q,
   output logic [AW:0]         busy_cnt
);

   logic wr_ok;
   logic rsv_ok;
   logic cnt_inc;
   logic cnt_dec;

   // The count moves only on real 0->1 / 1->0 flag transitions; a write that
   // collides with a reserve to the same register loses, so it never decrements.
   always_comb begin
      wr_ok   = wr_en  && !(ZERO_REG != 0 && wr_addr  == '0);
      rsv_ok  = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
      cnt_inc = rsv_ok && !busy_q[rsv_addr];
      cnt_dec = wr_ok && busy_q[wr_addr] && !(rsv_ok && rsv_addr == wr_addr);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q   <= '0;
         busy_cnt <= '0;
      end else begin
         if (wr_ok)
            busy_q[wr_addr] <= 1'b0;
         if (rsv_ok)
            busy_q[rsv_addr] <= 1'b1;
         case ({cnt_inc, cnt_dec})
            2'b10:   busy_cnt <= busy_cnt + (AW+1)'(1);
            2'b01:   busy_cnt <= busy_cnt - (AW+1)'(1);
            default: busy_cnt <= busy_cnt;
         endcase
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-to-read bypass, optional hard
// zero register and busy flags returned with each operand.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int DATA_W   = DEFAULT_DATA_W,
   parameter  int NUM_REGS = DEFAULT_NUM_REGS,
   parameter  int NUM_RD   = 2,
   parameter  int BYPASS   = 1,
   parameter  int ZERO_REG = 0,
   localparam int AW       = addr_width(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rsv_en,
   input  logic [AW-1:0]            rsv_addr,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic [AW:0]              busy_cnt
);

   logic [DATA_W-1:0]              rf [NUM_REGS];
   logic [NUM_REGS-1:0]            busy_q;
   logic [NUM_RD-1:0][DATA_W-1:0]  port_data;
   logic                           wr_ok;

   assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            rf[i] <= '0;
      end else if (wr_ok) begin
         rf[wr_addr] <= wr_data;
      end
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy_q   (busy_q),
      .busy_cnt (busy_cnt)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0]     addr;
      logic [DATA_W-1:0] data;
      logic              busy;

      assign addr = AW'(get_rd_addr(MAX_BUS_W'(rd_addr), i, AW));

      // Priority: hard zero register, then bypass of this cycle's write, then storage.
      always_comb begin
         data = rf[addr];
         busy = busy_q[addr];
         if (BYPASS != 0 && wr_en && wr_addr == addr) begin
            data = wr_data;
            busy = 1'b0;
         end
         if (ZERO_REG != 0 && addr == '0) begin
            data = '0;
            busy = 1'b0;
         end
      end

      assign port_data[i] = data;
      assign rd_busy[i]   = busy;
   end

   always_comb begin
      logic [MAX_BUS_W-1:0] bus;
      bus = '0;
      for (int i = 0; i < NUM_RD; i++)
         bus = put_rd_data(bus, i, DATA_W, MAX_FIELD_W'(port_data[i]));
      rd_data = (NUM_RD*DATA_W)'(bus);
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a default instance (16b, 2 ports, bypass)
// and a zero-register instance (32b, 3 ports).
module tb_regfile_sb;

   logic        clk = 1'b0;

   logic        reset;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [15:0] wr_data;
   logic        rsv_en;
   logic [1:0]  rsv_addr;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data;
   logic [1:0]  rd_busy;
   logic [2:0]  busy_cnt;

   logic        z_reset;
   logic        z_wr_en;
   logic [1:0]  z_wr_addr;
   logic [31:0] z_wr_data;
   logic        z_rsv_en;
   logic [1:0]  z_rsv_addr;
   logic [5:0]  z_rd_addr;
   logic [95:0] z_rd_data;
   logic [2:0]  z_rd_busy;
   logic [2:0]  z_busy_cnt;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   regfile_sb #(
      .DATA_W   (16),
      .NUM_REGS (4),
      .NUM_RD   (2),
      .BYPASS   (1),
      .ZERO_REG (0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .busy_cnt (busy_cnt)
   );

   regfile_sb #(
      .DATA_W   (32),
      .NUM_REGS (4),
      .NUM_RD   (3),
      .BYPASS   (1),
      .ZERO_REG (1)
   ) dut_z (
      .clk      (clk),
      .reset    (z_reset),
      .wr_en    (z_wr_en),
      .wr_addr  (z_wr_addr),
      .wr_data  (z_wr_data),
      .rsv_en   (z_rsv_en),
      .rsv_addr (z_rsv_addr),
      .rd_addr  (z_rd_addr),
      .rd_data  (z_rd_data),
      .rd_busy  (z_rd_busy),
      .busy_cnt (z_busy_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; z_reset = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
      z_wr_en = 1'b0; z_wr_addr = '0; z_wr_data = '0; z_rsv_en = 1'b0; z_rsv_addr = '0; z_rd_addr = '0;
      tick(); tick();
      reset = 1'b0; z_reset = 1'b0;
      #1;
      checks++;
      if (busy_cnt !== 3'd0) $display("[TB] FAIL reset_cnt_initial: got %0d expected 0", busy_cnt);
      else passed++;

      wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'hBEEF;
      tick();
      wr_en = 1'b0; rd_addr = {2'd0, 2'd2};
      #1;
      checks++;
      if (rd_data[15:0] !== 16'hBEEF) $display("[TB] FAIL pre_reset_write: got %h expected beef", rd_data[15:0]);
      else passed++;

      // Writes and reserves presented during reset must be ignored.
      reset = 1'b1; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h1111; rsv_en = 1'b1; rsv_addr = 2'd1;
      tick();
      reset = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
      rd_addr = {2'd1, 2'd0};
      #1;
      checks++;
      if (rd_data !== 32'h0) $display("[TB] FAIL reset_r0_r1: got %h expected 00000000", rd_data);
      else passed++;
      checks++;
      if (rd_busy !== 2'b00) $display("[TB] FAIL reset_busy: got %b expected 00", rd_busy);
      else passed++;
      rd_addr = {2'd3, 2'd2};
      #1;
      checks++;
      if (rd_data !== 32'h0) $display("[TB] FAIL reset_r2_r3: got %h expected 00000000", rd_data);
      else passed++;
      checks++;
      if (busy_cnt !== 3'd0) $display("[TB] FAIL reset_cnt: got %0d expected 0", busy_cnt);
      else passed++;
   endtask

   task automatic test_write_read;
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h1234;
      tick();
      wr_addr = 2'd3; wr_data = 16'hA5A5; rd_addr = {2'd1, 2'd3};
      #1;
      checks++;
      if (rd_data[15:0] !== 16'hA5A5) $display("[TB] FAIL bypass_r3: got %h expected a5a5", rd_data[15:0]);
      else passed++;
      checks++;
      if (rd_data[31:16] !== 16'h1234) $display("[TB] FAIL read_r1_during_write: got %h expected 1234", rd_data[31:16]);
      else passed++;
      tick();
      wr_en = 1'b0; rd_addr = {2'd3, 2'd1};
      #1;
      checks++;
      if (rd_data !== 32'hA5A5_1234) $display("[TB] FAIL read_r1_r3: got %h expected a5a51234", rd_data);
      else passed++;
   endtask

   task automatic test_scoreboard;
      rsv_en = 1'b1; rsv_addr = 2'd2; rd_addr = {2'd0, 2'd2};
      #1;
      checks++;
      if (rd_busy[0] !== 1'b0) $display("[TB] FAIL rsv_not_visible_same_cycle: got %b expected 0", rd_busy[0]);
      else passed++;
      tick();
      rsv_en = 1'b0;
      #1;
      checks++;
      if (rd_busy !== 2'b01) $display("[TB] FAIL rsv_r2_busy: got %b expected 01", rd_busy);
      else passed++;
      checks++;
      if (busy_cnt !== 3'd1) $display("[TB] FAIL rsv_r2_cnt: got %0d expected 1", busy_cnt);
      else passed++;

      wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h0F0F;
      #1;
      checks++;
      if (rd_busy[0] !== 1'b0 || rd_data[15:0] !== 16'h0F0F)
         $display("[TB] FAIL wb_bypass_r2: got busy %b data %h expected busy 0 data 0f0f", rd_busy[0], rd_data[15:0]);
      else passed++;
      tick();
      wr_en = 1'b0;
      #1;
      checks++;
      if (rd_busy[0] !== 1'b0 || rd_data[15:0] !== 16'h0F0F)
         $display("[TB] FAIL wb_r2_after: got busy %b data %h expected busy 0 data 0f0f", rd_busy[0], rd_data[15:0]);
      else passed++;
      checks++;
      if (busy_cnt !== 3'd0) $display("[TB] FAIL wb_r2_cnt: got %0d expected 0", busy_cnt);
      else passed++;
   endtask

   task automatic test_simultaneous;
      rsv_en = 1'b1; rsv_addr = 2'd1;
      tick();
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h7777;
      tick();
      wr_en = 1'b0; rsv_en = 1'b0; rd_addr = {2'd0, 2'd1};
      #1;
      checks++;
      if (rd_data[15:0] !== 16'h7777 || rd_busy[0] !== 1'b1)
         $display("[TB] FAIL wr_rsv_busy_r1: got data %h busy %b expected data 7777 busy 1", rd_data[15:0], rd_busy[0]);
      else passed++;
      checks++;
      if (busy_cnt !== 3'd1) $display("[TB] FAIL wr_rsv_busy_cnt: got %0d expected 1", busy_cnt);
      else passed++;

      rsv_en = 1'b1; rsv_addr = 2'd1;
      tick();
      rsv_en = 1'b0;
      #1;
      checks++;
      if (busy_cnt !== 3'd1) $display("[TB] FAIL rereserve_cnt: got %0d expected 1", busy_cnt);
      else passed++;

      // Same-cycle write and reserve to an idle register: becomes busy, count rises.
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = 16'h3333; rsv_en = 1'b1; rsv_addr = 2'd3;
      tick();
      wr_en = 1'b0; rsv_en = 1'b0; rd_addr = {2'd1, 2'd3};
      #1;
      checks++;
      if (rd_data !== 32'h7777_3333 || rd_busy !== 2'b11 || busy_cnt !== 3'd2)
         $display("[TB] FAIL wr_rsv_idle_r3: got data %h busy %b cnt %0d expected 77773333 11 2", rd_data, rd_busy, busy_cnt);
      else passed++;

      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h0101;
      tick();
      wr_addr = 2'd3; wr_data = 16'h0303;
      tick();
      wr_en = 1'b0;
      #1;
      checks++;
      if (busy_cnt !== 3'd0 || rd_busy !== 2'b00)
         $display("[TB] FAIL drain_r1_r3: got cnt %0d busy %b expected 0 00", busy_cnt, rd_busy);
      else passed++;
   endtask

   task automatic test_fill_drain;
      for (int i = 0; i < 4; i++) begin
         rsv_en = 1'b1; rsv_addr = 2'(i);
         tick();
         rsv_en = 1'b0;
         #1;
         checks++;
         if (busy_cnt !== 3'(i + 1)) $display("[TB] FAIL fill_cnt_%0d: got %0d expected %0d", i, busy_cnt, i + 1);
         else passed++;
      end
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_addr = 2'(i); wr_data = 16'h1000 + 16'(i);
         tick();
         wr_en = 1'b0;
         #1;
         checks++;
         if (busy_cnt !== 3'(3 - i)) $display("[TB] FAIL drain_cnt_%0d: got %0d expected %0d", i, busy_cnt, 3 - i);
         else passed++;
      end

      // Reserve and write on different registers in one cycle act independently.
      rsv_en = 1'b1; rsv_addr = 2'd0; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h2222;
      tick();
      rsv_addr = 2'd1; wr_addr = 2'd0; wr_data = 16'h2020;
      tick();
      rsv_en = 1'b0; wr_en = 1'b0; rd_addr = {2'd1, 2'd0};
      #1;
      checks++;
      if (busy_cnt !== 3'd1 || rd_busy !== 2'b10 || rd_data !== 32'h2222_2020)
         $display("[TB] FAIL swap_rsv_wr: got cnt %0d busy %b data %h expected 1 10 22222020", busy_cnt, rd_busy, rd_data);
      else passed++;

      rsv_en = 1'b1; rsv_addr = 2'd2;
      tick();
      rsv_en = 1'b0;
      #1;
      checks++;
      if (busy_cnt !== 3'd2) $display("[TB] FAIL two_busy_cnt: got %0d expected 2", busy_cnt);
      else passed++;
      reset = 1'b1;
      tick();
      reset = 1'b0; rd_addr = {2'd2, 2'd1};
      #1;
      checks++;
      if (busy_cnt !== 3'd0 || rd_busy !== 2'b00)
         $display("[TB] FAIL reset_with_busy: got cnt %0d busy %b expected 0 00", busy_cnt, rd_busy);
      else passed++;
   endtask

   task automatic test_zero_reg;
      z_wr_en = 1'b1; z_wr_addr = 2'd0; z_wr_data = 32'hFFFF_FFFF;
      z_rsv_en = 1'b1; z_rsv_addr = 2'd0;
      z_rd_addr = {2'd2, 2'd1, 2'd0};
      #1;
      checks++;
      if (z_rd_data[31:0] !== 32'h0 || z_rd_busy[0] !== 1'b0)
         $display("[TB] FAIL zero_bypass: got data %h busy %b expected 00000000 0", z_rd_data[31:0], z_rd_busy[0]);
      else passed++;
      tick();
      z_wr_en = 1'b0; z_rsv_en = 1'b0;
      #1;
      checks++;
      if (z_rd_data[31:0] !== 32'h0 || z_rd_busy[0] !== 1'b0 || z_busy_cnt !== 3'd0)
         $display("[TB] FAIL zero_after: got data %h busy %b cnt %0d expected 00000000 0 0", z_rd_data[31:0], z_rd_busy[0], z_busy_cnt);
      else passed++;

      z_wr_en = 1'b1; z_wr_addr = 2'd1; z_wr_data = 32'hDEAD_BEEF;
      z_rsv_en = 1'b1; z_rsv_addr = 2'd2;
      tick();
      z_wr_en = 1'b0; z_rsv_en = 1'b0;
      #1;
      checks++;
      if (z_rd_data !== {32'h0, 32'hDEAD_BEEF, 32'h0} || z_rd_busy !== 3'b100 || z_busy_cnt !== 3'd1)
         $display("[TB] FAIL zero_other_ports: got data %h busy %b cnt %0d expected 00000000deadbeef00000000 100 1",
                  z_rd_data, z_rd_busy, z_busy_cnt);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_scoreboard();
      test_simultaneous();
      test_fill_drain();
      test_zero_reg();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
